hazard_sequencer: RTL and testbench

- Parametrised pipeline hazard controller for the F / D / EXM / WB pipeline.
- Handles four hazard sources:
  - branch flushes;
  - multi-word PC push/pop (PC wider than the memory word), sequenced over several cycles;
  - load-use bubbles;
  - interrupt pending/injection.
- Sits beside the F/D and D/EXM buffers and drives their stall/flush controls and the fetch branch select.

---
 rtl/hazard_sequencer_if.sv | 64 ++++++
 rtl/hazard_sequencer.sv | 167 ++++++++++++++++
 tb/tb_hazard_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
// Hazard control bundle between the pipeline buffers and hazard_sequencer.
// The pipeline side (master) presents the EXM/decode status; the sequencer
// (slave) returns stall/flush/select controls combinationally in the same cycle.
//
// Control semantics: there is no valid/ready pairing on this bundle. Every
// input is a level qualified by the current clock cycle only. Every output is
// meaningful in the cycle it is asserted and must be acted on in that same
// cycle by the F/D and D/EXM buffers and the fetch PC mux.
interface hazard_sequencer_if #(
    parameter int PC_WIDTH   = 32,
    parameter int MEM_WIDTH  = 16,
    parameter int REG_ADDR_W = 3
);
    localparam int WORDS = PC_WIDTH / MEM_WIDTH;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    // EXM stage status
    logic                  i_push_pc;
    logic                  i_pop_pc;
    logic                  i_branch_decision;
    logic                  i_exm_mem_read;
    logic                  i_exm_write_back;
    logic [REG_ADDR_W-1:0] i_exm_rd;

    // Decode stage status
    logic [REG_ADDR_W-1:0] i_dec_rs;
    logic [REG_ADDR_W-1:0] i_dec_rd;
    logic                  i_dec_use_rs;
    logic                  i_dec_use_rd;

    // External interrupt request
    logic                  i_interrupt;

    // Buffer and fetch controls
    logic                  o_stall_f_d;
    logic                  o_stall_d_em;
    logic                  o_flush_f_d;
    logic                  o_flush_d_em;
    logic                  o_branch_decision;
    logic [CW-1:0]         o_word_sel;
    logic                  o_busy;
    logic                  o_int_inject;
    logic                  o_int_pending;

    modport master (
        output i_push_pc, i_pop_pc, i_branch_decision,
        output i_exm_mem_read, i_exm_write_back, i_exm_rd,
        output i_dec_rs, i_dec_rd, i_dec_use_rs, i_dec_use_rd,
        output i_interrupt,
        input  o_stall_f_d, o_stall_d_em, o_flush_f_d, o_flush_d_em,
        input  o_branch_decision, o_word_sel, o_busy,
        input  o_int_inject, o_int_pending
    );

    modport slave (
        input  i_push_pc, i_pop_pc, i_branch_decision,
        input  i_exm_mem_read, i_exm_write_back, i_exm_rd,
        input  i_dec_rs, i_dec_rd, i_dec_use_rs, i_dec_use_rd,
        input  i_interrupt,
        output o_stall_f_d, o_stall_d_em, o_flush_f_d, o_flush_d_em,
        output o_branch_decision, o_word_sel, o_busy,
        output o_int_inject, o_int_pending
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for the F / D / EXM / WB pipeline.
// Resolves, in priority order: multi-word PC push/pop sequencing, taken
// branches, load-use bubbles and interrupt injection. All controls are
// combinational from the registered state and the current inputs; reset
// forces every control low immediately.
module hazard_sequencer #(
    parameter int PC_WIDTH   = 32,
    parameter int MEM_WIDTH  = 16,
    parameter int REG_ADDR_W = 3,
    parameter int INT_ENABLE = 1
) (
    input logic                i_clk,
    input logic                i_reset,
    hazard_sequencer_if.slave  bus
);
    localparam int WORDS = PC_WIDTH / MEM_WIDTH;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Index of the final PC word of a push/pop sequence.
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          int_prev_q;

    // Local copies of the register addresses at this block's own width.
    logic [REG_ADDR_W-1:0] exm_rd;
    logic [REG_ADDR_W-1:0] dec_rs;
    logic [REG_ADDR_W-1:0] dec_rd;

    logic          pc_op;
    logic          load_use;
    logic          int_req;
    logic          int_rise;
    logic          take_int;

    logic          stall_f_d_c;
    logic          stall_d_em_c;
    logic          flush_f_d_c;
    logic          flush_d_em_c;
    logic          branch_c;
    logic [CW-1:0] word_sel_c;
    logic          busy_c;
    logic          inject_c;

    assign exm_rd = bus.i_exm_rd;
    assign dec_rs = bus.i_dec_rs;
    assign dec_rd = bus.i_dec_rd;

    // Simultaneous push and pop is a single sequence; both walk the words alike.
    assign pc_op = bus.i_push_pc | bus.i_pop_pc;

    // Loaded value is not available to decode until it reaches WB.
    assign load_use = bus.i_exm_mem_read & bus.i_exm_write_back &
                      ((bus.i_dec_use_rs & (dec_rs == exm_rd)) |
                       (bus.i_dec_use_rd & (dec_rd == exm_rd)));

    // Interrupt requests are recognised on their rising edge so a held level
    // is taken only once; with the feature absent the request is discarded.
    assign int_req  = (INT_ENABLE != 0) ? bus.i_interrupt : 1'b0;
    assign int_rise = int_req & ~int_prev_q;

    // Next-state and control decode; defaults first, then the priority chain.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_f_d_c  = 1'b0;
        stall_d_em_c = 1'b0;
        flush_f_d_c  = 1'b0;
        flush_d_em_c = 1'b0;
        branch_c     = 1'b0;
        word_sel_c   = '0;
        busy_c       = 1'b0;
        inject_c     = 1'b0;
        take_int     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pc_op) begin
                    // Word 0 goes out this cycle.
                    word_sel_c = '0;
                    if (WORDS == 1) begin
                        // Single-word PC: word 0 is also the final word.
                        branch_c     = bus.i_branch_decision;
                        flush_f_d_c  = bus.i_branch_decision;
                        flush_d_em_c = bus.i_branch_decision;
                    end else begin
                        stall_f_d_c  = 1'b1;
                        stall_d_em_c = 1'b1;
                        state_d      = SEQ;
                        cnt_d        = CW'(1);
                    end
                end else if (bus.i_branch_decision) begin
                    branch_c     = 1'b1;
                    flush_f_d_c  = 1'b1;
                    flush_d_em_c = 1'b1;
                end else if (load_use) begin
                    // One bubble: hold fetch/decode, squash what enters EXM.
                    stall_f_d_c  = 1'b1;
                    flush_d_em_c = 1'b1;
                end else if (pend_q) begin
                    // Decode swaps in the interrupt push; the fetched word is dropped.
                    inject_c    = 1'b1;
                    flush_f_d_c = 1'b1;
                    take_int    = 1'b1;
                end
            end

            SEQ: begin
                word_sel_c = cnt_q;
                busy_c     = 1'b1;
                if (cnt_q == LAST_WORD) begin
                    // Only the final word may redirect fetch (ret/rti target).
                    branch_c     = bus.i_branch_decision;
                    flush_f_d_c  = bus.i_branch_decision;
                    flush_d_em_c = bus.i_branch_decision;
                    state_d      = IDLE;
                    cnt_d        = '0;
                end else begin
                    stall_f_d_c  = 1'b1;
                    stall_d_em_c = 1'b1;
                    cnt_d        = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new request edge in the taking cycle survives the clear.
        pend_d = int_rise | (pend_q & ~take_int);
    end

    // State, word counter, pending flag and interrupt edge history.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            int_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            int_prev_q <= int_req;
        end
    end

    // Controls are forced low while reset is asserted, independent of inputs.
    assign bus.o_stall_f_d       = i_reset & stall_f_d_c;
    assign bus.o_stall_d_em      = i_reset & stall_d_em_c;
    assign bus.o_flush_f_d       = i_reset & flush_f_d_c;
    assign bus.o_flush_d_em      = i_reset & flush_d_em_c;
    assign bus.o_branch_decision = i_reset & branch_c;
    assign bus.o_word_sel        = i_reset ? word_sel_c : '0;
    assign bus.o_busy            = i_reset & busy_c;
    assign bus.o_int_inject      = i_reset & inject_c;
    assign bus.o_int_pending     = i_reset & pend_q;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: four instances (WORDS = 2, 4, 1 and WORDS = 2
// without interrupt logic) share one stimulus. Directed vectors, hand-written
// multi-cycle sequences and a randomized run against a rule-level model.
module tb_hazard_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic       push, pop, bd, mr, wb, intr, urs, urd;
    logic [2:0] erd, rs, rd;

    // Output vector layout: {sfd, sde, ffd, fde, br, busy, inj, pend, sel[1:0]}
    localparam logic [9:0] O_SFD  = 10'h200;
    localparam logic [9:0] O_SDE  = 10'h100;
    localparam logic [9:0] O_FFD  = 10'h080;
    localparam logic [9:0] O_FDE  = 10'h040;
    localparam logic [9:0] O_BR   = 10'h020;
    localparam logic [9:0] O_BUSY = 10'h010;
    localparam logic [9:0] O_INJ  = 10'h008;
    localparam logic [9:0] O_PEND = 10'h004;

    logic [9:0] outv [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int MW = (g == 1) ? 8 : (g == 2) ? 32 : 16;
        localparam int IE = (g == 3) ? 0 : 1;

        hazard_sequencer_if #(.PC_WIDTH(32), .MEM_WIDTH(MW), .REG_ADDR_W(3)) bus ();

        assign bus.i_push_pc         = push;
        assign bus.i_pop_pc          = pop;
        assign bus.i_branch_decision = bd;
        assign bus.i_exm_mem_read    = mr;
        assign bus.i_exm_write_back  = wb;
        assign bus.i_exm_rd          = erd;
        assign bus.i_dec_rs          = rs;
        assign bus.i_dec_rd          = rd;
        assign bus.i_dec_use_rs      = urs;
        assign bus.i_dec_use_rd      = urd;
        assign bus.i_interrupt       = intr;

        hazard_sequencer #(
            .PC_WIDTH(32), .MEM_WIDTH(MW), .REG_ADDR_W(3), .INT_ENABLE(IE)
        ) u_dut (
            .i_clk   (clk),
            .i_reset (rst_n),
            .bus     (bus)
        );

        assign outv[g] = {bus.o_stall_f_d, bus.o_stall_d_em, bus.o_flush_f_d,
                          bus.o_flush_d_em, bus.o_branch_decision, bus.o_busy,
                          bus.o_int_inject, bus.o_int_pending, 2'(bus.o_word_sel)};
    end

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int g, input logic [9:0] exp);
        n_total++;
        if (outv[g] === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %b expected %b", name, g, outv[g], exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        push = 0; pop = 0; bd = 0; mr = 0; wb = 0; intr = 0; urs = 0; urd = 0;
        erd = 3'd0; rs = 3'd0; rd = 3'd0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int m_seq  [4];   // index of the next PC word of an open sequence, 0 = none
    bit m_pend [4];
    bit m_prev;

    function automatic int words_of(input int g);
        return (g == 1) ? 4 : (g == 2) ? 1 : 2;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 4; g++) begin
            m_seq[g]  = 0;
            m_pend[g] = 0;
        end
        m_prev = 0;
    endtask

    task automatic model_eval(input int g, output logic [9:0] e,
                              output int nseq, output bit npend);
        int  w;
        int  word;
        bit  lu;
        bit  take;
        bit  ie;
        w    = words_of(g);
        ie   = (g != 3);
        e    = '0;
        nseq = 0;
        take = 0;
        lu   = mr && wb && ((urs && rs == erd) || (urd && rd == erd));
        if (m_seq[g] > 0 || push || pop) begin
            word   = m_seq[g];
            e[1:0] = 2'(word);
            if (m_seq[g] > 0) e |= O_BUSY;
            if (word == w - 1) begin
                if (bd) e |= O_BR | O_FFD | O_FDE;
                nseq = 0;
            end else begin
                e |= O_SFD | O_SDE;
                nseq = word + 1;
            end
        end else if (bd) begin
            e |= O_BR | O_FFD | O_FDE;
        end else if (lu) begin
            e |= O_SFD | O_FDE;
        end else if (ie && m_pend[g]) begin
            e |= O_INJ | O_FFD;
            take = 1;
        end
        if (ie && m_pend[g]) e |= O_PEND;
        npend = ie && ((intr && !m_prev) || (m_pend[g] && !take));
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic       bd, mr, wb;
        logic [2:0] erd, rs, rd;
        logic       urs, urd;
        logic [9:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic b, input logic m, input logic w,
                                input logic [2:0] e, input logic [2:0] s,
                                input logic [2:0] d, input logic us,
                                input logic ud, input logic [9:0] x);
        vec_t v;
        v.bd = b; v.mr = m; v.wb = w; v.erd = e; v.rs = s; v.rd = d;
        v.urs = us; v.urd = ud; v.exp = x;
        return v;
    endfunction

    vec_t vecs [9];

    initial begin
        logic [9:0] e;
        int         ns [4];
        bit         np [4];

        vecs[0] = mk(1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, O_BR | O_FFD | O_FDE);
        vecs[1] = mk(0, 1, 1, 3'd3, 3'd3, 3'd0, 1, 0, O_SFD | O_FDE);
        vecs[2] = mk(0, 1, 1, 3'd4, 3'd3, 3'd0, 1, 0, '0);
        vecs[3] = mk(0, 1, 1, 3'd3, 3'd3, 3'd0, 0, 0, '0);
        vecs[4] = mk(0, 1, 0, 3'd3, 3'd3, 3'd0, 1, 0, '0);
        vecs[5] = mk(0, 1, 1, 3'd5, 3'd0, 3'd5, 0, 1, O_SFD | O_FDE);
        vecs[6] = mk(0, 0, 1, 3'd3, 3'd3, 3'd3, 1, 1, '0);
        vecs[7] = mk(1, 1, 1, 3'd3, 3'd3, 3'd0, 1, 0, O_BR | O_FFD | O_FDE);
        vecs[8] = mk(0, 1, 1, 3'd2, 3'd2, 3'd6, 0, 1, '0);

        // ---- reset: outputs low even with active inputs ----
        drive_idle();
        push = 1; bd = 1; mr = 1; wb = 1; urs = 1;
        tick();
        #2;
        for (int g = 0; g < 4; g++) chk("in_reset", g, '0);
        drive_idle();
        tick();
        rst_n = 1;
        model_reset();
        #2;
        for (int g = 0; g < 4; g++) chk("after_reset", g, '0);
        tick();

        // ---- single-cycle vectors, each followed by an idle cycle ----
        for (int i = 0; i < 9; i++) begin
            bd = vecs[i].bd; mr = vecs[i].mr; wb = vecs[i].wb;
            erd = vecs[i].erd; rs = vecs[i].rs; rd = vecs[i].rd;
            urs = vecs[i].urs; urd = vecs[i].urd;
            #2;
            chk($sformatf("vec%0d", i), 0, vecs[i].exp);
            chk($sformatf("vec%0d", i), 3, vecs[i].exp);
            tick();
            drive_idle();
            #2;
            chk($sformatf("vec%0d_next", i), 0, '0);
            tick();
        end

        // ---- pop with branch held, WORDS = 2 ----
        do_reset();
        pop = 1; bd = 1;
        #2; chk("pop_w0", 0, O_SFD | O_SDE);
        chk("pop_single_word", 2, O_BR | O_FFD | O_FDE);
        tick();
        #2; chk("pop_w1", 0, O_BR | O_FFD | O_FDE | O_BUSY | 10'd1);
        tick();
        drive_idle();
        #2; chk("pop_done", 0, '0);

        // ---- push, WORDS = 4 and WORDS = 1; branch ignored on non-final word ----
        do_reset();
        push = 1;
        #2; chk("push4_w0", 1, O_SFD | O_SDE);
        chk("push1_w0", 2, '0);
        tick();
        push = 0;
        #2; chk("push4_w1", 1, O_SFD | O_SDE | O_BUSY | 10'd1);
        chk("push1_after", 2, '0);
        tick();
        bd = 1;
        #2; chk("push4_w2_bd_ignored", 1, O_SFD | O_SDE | O_BUSY | 10'd2);
        tick();
        bd = 0;
        #2; chk("push4_w3", 1, O_BUSY | 10'd3);
        tick();
        #2; chk("push4_done", 1, '0);

        // ---- asynchronous reset in the middle of a WORDS = 4 sequence ----
        do_reset();
        push = 1;
        tick();
        push = 0; bd = 1;
        #2; chk("rst_seq_pre", 1, O_SFD | O_SDE | O_BUSY | 10'd1);
        rst_n = 0;
        #1;
        for (int g = 0; g < 4; g++) chk("rst_seq_async", g, '0);
        bd = 0;
        tick();
        rst_n = 1;
        model_reset();
        #2; chk("rst_seq_release", 1, '0);
        tick();
        #2; chk("rst_seq_idle", 1, '0);

        // ---- interrupt pulse during a sequence, taken after load-use ----
        do_reset();
        push = 1;
        #2; chk("int_seq_w0", 0, O_SFD | O_SDE);
        tick();
        push = 0; intr = 1;
        #2; chk("int_seq_w1", 0, O_BUSY | 10'd1);
        tick();
        intr = 0; mr = 1; wb = 1; erd = 3'd3; rs = 3'd3; urs = 1;
        #2; chk("int_lu_blocks", 0, O_SFD | O_FDE | O_PEND);
        chk("noint_lu", 3, O_SFD | O_FDE);
        tick();
        drive_idle();
        #2; chk("int_inject", 0, O_INJ | O_FFD | O_PEND);
        chk("noint_quiet", 3, '0);
        tick();
        #2; chk("int_cleared", 0, '0);
        chk("noint_quiet2", 3, '0);

        // ---- held level taken once; request edge in the taking cycle kept ----
        do_reset();
        intr = 1;
        #2; chk("lvl_c0", 0, '0);
        tick();
        #2; chk("lvl_take", 0, O_INJ | O_FFD | O_PEND);
        chk("lvl_noint", 3, '0);
        tick();
        #2; chk("lvl_no_retake", 0, '0);
        tick();
        intr = 0;
        tick();
        intr = 1;
        #2; chk("sw_c0", 0, '0);
        tick();
        intr = 0; bd = 1;
        #2; chk("sw_branch_blocks", 0, O_BR | O_FFD | O_FDE | O_PEND);
        tick();
        intr = 1; bd = 0;
        #2; chk("sw_take_and_set", 0, O_INJ | O_FFD | O_PEND);
        chk("sw_noint", 3, '0);
        tick();
        intr = 0;
        #2; chk("sw_retake_new", 0, O_INJ | O_FFD | O_PEND);
        tick();
        #2; chk("sw_done", 0, '0);

        // ---- randomized run against the rule-level model ----
        do_reset();
        for (int c = 0; c < 500; c++) begin
            push = ($urandom_range(0, 9) == 0);
            pop  = ($urandom_range(0, 9) == 0);
            bd   = ($urandom_range(0, 5) == 0);
            mr   = 1'($urandom_range(0, 1));
            wb   = 1'($urandom_range(0, 1));
            urs  = 1'($urandom_range(0, 1));
            urd  = 1'($urandom_range(0, 1));
            erd  = 3'($urandom_range(0, 3));
            rs   = 3'($urandom_range(0, 3));
            rd   = 3'($urandom_range(0, 3));
            intr = ($urandom_range(0, 3) == 0);
            #2;
            for (int g = 0; g < 4; g++) begin
                model_eval(g, e, ns[g], np[g]);
                chk($sformatf("rand_c%0d", c), g, e);
            end
            tick();
            for (int g = 0; g < 4; g++) begin
                m_seq[g]  = ns[g];
                m_pend[g] = np[g];
            end
            m_prev = intr;
        end

        // ---- final report ----
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
